control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired Moore control unit for the Mini SRC datapath. It takes over the T-state signal sequencing that benches currently drive by hand. It runs the common fetch (T0–T2), decodes IR[31:27] and issues per-instruction execute steps (T3–T7) into the existing bus/register enables, then returns to T0. It sits beside CPUproject and drives its control inputs directly.

Parameters:
OPW, 5, opcode field width (IR[31:27])
WORD, 32, IR width

Ports:
clk  in  1  system clock, all state changes on rising edge
clr  in  1  synchronous active-high reset
ir  in  WORD  IR contents; stable from T3 onward
con_ff  in  1  CON FF output (branch condition)
bus_src  out  10  one-hot bus driver: [9]BAout [8]Rout [7]Cout [6]InPortout [5]LOout [4]HIout [3]ZLowout [2]ZHighout [1]MDRout [0]PCout
reg_ld  out  12  load enables: [11]CONin [10]OutPortin [9]Rin [8]HIin [7]LOin [6]ZHighIn [5]ZLowIn [4]Yin [3]IRin [2]MDRin [1]PCin [0]MARin
gr_sel  out  3  {Gra,Grb,Grc}
inc_pc  out  1  IncPC (ALU passes bus+1)
mem_read  out  1  Read (MDR sources RAM)
mem_write  out  1  RAM write enable
alu_add  out  1  force ALU ADD regardless of opcode
link_r15  out  1  with Rin, redirect register write to R15
run  out  1  high except in RST and HALT

Behaviour:
- States: RST, T0..T7, HALT. Registered state; outputs are a pure decode of state plus opcode plus con_ff. Each state lasts 1 clk.
- clr=1 at an edge forces RST from any state, including mid-instruction. In RST all outputs are 0 and run=0. Next state is T0.
- bus_src is always zero or one-hot; never two drivers.
- Fetch:
  - T0: PCout, MARin, inc_pc, ZLowIn
  - T1: ZLowout, PCin, mem_read, MDRin
  - T2: MDRout, IRin
  - T3 decodes ir[31:27].
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010. Undefined codes (11011–11111) execute as nop.
- ALU reg (add..or): T3 Grb Rout Yin; T4 Grc Rout ZLowIn; T5 ZLowout Gra Rin.
- ALU imm (addi/andi/ori): T3 Grb Rout Yin; T4 Cout ZLowIn; T5 ZLowout Gra Rin.
- neg/not: T3 Grb Rout ZLowIn; T4 ZLowout Gra Rin.
- mul/div: T3 Gra Rout Yin; T4 Grb Rout ZHighIn ZLowIn; T5 ZLowout LOin; T6 ZHighout HIin.
- ldi: T3 Grb BAout Yin; T4 Cout ZLowIn alu_add; T5 ZLowout Gra Rin.
- ld: same T3–T4 as ldi; T5 ZLowout MARin; T6 mem_read MDRin; T7 MDRout Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDRin (mem_read=0); T7 mem_write.
- br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ZLowIn alu_add; T6 ZLowout, plus PCin only if con_ff=1. con_ff is sampled combinationally in T6.
- jr: T3 Gra Rout PCin.
- jal: T3 PCout Rin link_r15; T4 Gra Rout PCin.
- in: T3 InPortout Gra Rin.
- out: T3 Gra Rout OutPortin.
- mfhi: T3 HIout Gra Rin.
- mflo: T3 LOout Gra Rin.
- nop: T2 goes directly to T0.
- halt: T3 goes to HALT. HALT holds all outputs 0, run=0, and exits only via clr.
- After the last listed step of each instruction the next state is T0. Signals not listed for a state are 0.
- ir changes outside IRin-controlled timing are ignored except where the decode uses them (T3..T7).

Test Plan:
- clr pulse, then ir=32'h98800000 (jr R1): states run T0,T1,T2,T3,T0. At T0 bus_src=10'h001, reg_ld=12'h021, inc_pc=1. At T3 bus_src=10'h100, reg_ld=12'h002, gr_sel=3'b100.
- ld (ir=32'h00800055): 8 cycles T0..T7. At T4 alu_add=1 and bus_src=10'h080. At T6 mem_read=1 and reg_ld=12'h004. At T7 reg_ld=12'h200 with gr_sel=100.
- br with con_ff=0, then repeated with con_ff=1: T6 reg_ld=12'h000 vs 12'h002. bus_src=10'h008 in both runs.
- mul (opcode 01110): T5 reg_ld=12'h080, T6 bus_src=10'h004 with reg_ld=12'h100. Next state T0.
- halt: reaches HALT with run=0 and all outputs 0 for 20 cycles. clr then gives RST, then T0 with run=1.
- clr asserted in T5 of an add: next cycle RST with all outputs 0. The following cycle is T0. Assertion every cycle: bus_src is $onehot0.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the Mini SRC datapath.
// The sequencer uses the master modport; the datapath (or a bench) uses slave.
interface control_sequencer_if #(
  parameter int unsigned WORD = 32
);
  logic [WORD-1:0] ir;
  logic            con_ff;
  logic [9:0]      bus_src;
  logic [11:0]     reg_ld;
  logic [2:0]      gr_sel;
  logic            inc_pc;
  logic            mem_read;
  logic            mem_write;
  logic            alu_add;
  logic            link_r15;
  logic            run;

  modport master (
    input  ir, con_ff,
    output bus_src, reg_ld, gr_sel, inc_pc, mem_read, mem_write, alu_add, link_r15, run
  );

  modport slave (
    output ir, con_ff,
    input  bus_src, reg_ld, gr_sel, inc_pc, mem_read, mem_write, alu_add, link_r15, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC datapath: common fetch in
// T0..T2, opcode-specific execute steps in T3..T7, then back to T0.
module control_sequencer #(
  parameter int unsigned OPW  = 5,
  parameter int unsigned WORD = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  control_sequencer_if.master  cs
);

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  // bus_src bit positions
  localparam int unsigned BBa = 9, BR = 8, BC = 7, BInPort = 6, BLo = 5, BHi = 4;
  localparam int unsigned BZLow = 3, BZHigh = 2, BMdr = 1, BPc = 0;
  // reg_ld bit positions
  localparam int unsigned LCon = 11, LOutPort = 10, LR = 9, LHi = 8, LLo = 7, LZHigh = 6;
  localparam int unsigned LZLow = 5, LY = 4, LIr = 3, LMdr = 2, LPc = 1, LMar = 0;
  // gr_sel bit positions
  localparam int unsigned GA = 2, GB = 1, GC = 0;

  localparam logic [OPW-1:0] OpLd   = OPW'(0),  OpLdi  = OPW'(1),  OpSt   = OPW'(2);
  localparam logic [OPW-1:0] OpAdd  = OPW'(3),  OpSub  = OPW'(4),  OpShr  = OPW'(5);
  localparam logic [OPW-1:0] OpShl  = OPW'(6),  OpRor  = OPW'(7),  OpRol  = OPW'(8);
  localparam logic [OPW-1:0] OpAnd  = OPW'(9),  OpOr   = OPW'(10), OpAddi = OPW'(11);
  localparam logic [OPW-1:0] OpAndi = OPW'(12), OpOri  = OPW'(13), OpMul  = OPW'(14);
  localparam logic [OPW-1:0] OpDiv  = OPW'(15), OpNeg  = OPW'(16), OpNot  = OPW'(17);
  localparam logic [OPW-1:0] OpBr   = OPW'(18), OpJr   = OPW'(19), OpJal  = OPW'(20);
  localparam logic [OPW-1:0] OpIn   = OPW'(21), OpOut  = OPW'(22), OpMfhi = OPW'(23);
  localparam logic [OPW-1:0] OpMflo = OPW'(24), OpNop  = OPW'(25), OpHalt = OPW'(26);

  state_e          state_q, state_d;
  logic [OPW-1:0]  op;
  logic            is_nop;
  logic [9:0]      bus_src;
  logic [11:0]     reg_ld;
  logic [2:0]      gr_sel;
  logic            inc_pc, mem_read, mem_write, alu_add, link_r15, run;
  logic            unused_ir;

  assign op        = cs.ir[WORD-1 -: OPW];
  assign unused_ir = ^cs.ir[WORD-OPW-1:0];
  // Undefined opcodes above halt behave like nop.
  assign is_nop    = (op >= OpNop) && (op != OpHalt);

  // State register; clr wins over every state, including HALT.
  always_ff @(posedge clk) begin
    if (clr) state_q <= StRst;
    else     state_q <= state_d;
  end

  // Next-state and Moore output decode from state, opcode and con_ff.
  always_comb begin
    state_d   = state_q;
    bus_src   = '0;
    reg_ld    = '0;
    gr_sel    = '0;
    inc_pc    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_add   = 1'b0;
    link_r15  = 1'b0;
    run       = 1'b0;
    unique case (state_q)
      StRst: state_d = StT0;
      StT0: begin
        run = 1'b1;
        bus_src[BPc] = 1'b1; reg_ld[LMar] = 1'b1; reg_ld[LZLow] = 1'b1; inc_pc = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        run = 1'b1;
        bus_src[BZLow] = 1'b1; reg_ld[LPc] = 1'b1; reg_ld[LMdr] = 1'b1; mem_read = 1'b1;
        state_d = StT2;
      end
      StT2: begin
        run = 1'b1;
        bus_src[BMdr] = 1'b1; reg_ld[LIr] = 1'b1;
        state_d = is_nop ? StT0 : StT3;
      end
      StT3: begin
        run = 1'b1;
        state_d = StT4;
        case (op)
          OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr, OpAddi, OpAndi, OpOri: begin
            gr_sel[GB] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LY] = 1'b1;
          end
          OpNeg, OpNot: begin
            gr_sel[GB] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LZLow] = 1'b1;
          end
          OpMul, OpDiv: begin
            gr_sel[GA] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LY] = 1'b1;
          end
          OpLd, OpLdi, OpSt: begin
            gr_sel[GB] = 1'b1; bus_src[BBa] = 1'b1; reg_ld[LY] = 1'b1;
          end
          OpBr: begin
            gr_sel[GA] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LCon] = 1'b1;
          end
          OpJr: begin
            gr_sel[GA] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LPc] = 1'b1; state_d = StT0;
          end
          OpJal: begin
            bus_src[BPc] = 1'b1; reg_ld[LR] = 1'b1; link_r15 = 1'b1;
          end
          OpIn: begin
            bus_src[BInPort] = 1'b1; gr_sel[GA] = 1'b1; reg_ld[LR] = 1'b1; state_d = StT0;
          end
          OpOut: begin
            gr_sel[GA] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LOutPort] = 1'b1; state_d = StT0;
          end
          OpMfhi: begin
            bus_src[BHi] = 1'b1; gr_sel[GA] = 1'b1; reg_ld[LR] = 1'b1; state_d = StT0;
          end
          OpMflo: begin
            bus_src[BLo] = 1'b1; gr_sel[GA] = 1'b1; reg_ld[LR] = 1'b1; state_d = StT0;
          end
          OpHalt:  state_d = StHalt;
          default: state_d = StT0;
        endcase
      end
      StT4: begin
        run = 1'b1;
        state_d = StT5;
        case (op)
          OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr: begin
            gr_sel[GC] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LZLow] = 1'b1;
          end
          OpAddi, OpAndi, OpOri: begin
            bus_src[BC] = 1'b1; reg_ld[LZLow] = 1'b1;
          end
          OpNeg, OpNot: begin
            bus_src[BZLow] = 1'b1; gr_sel[GA] = 1'b1; reg_ld[LR] = 1'b1; state_d = StT0;
          end
          OpMul, OpDiv: begin
            gr_sel[GB] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LZHigh] = 1'b1; reg_ld[LZLow] = 1'b1;
          end
          OpLd, OpLdi, OpSt: begin
            bus_src[BC] = 1'b1; reg_ld[LZLow] = 1'b1; alu_add = 1'b1;
          end
          OpBr: begin
            bus_src[BPc] = 1'b1; reg_ld[LY] = 1'b1;
          end
          OpJal: begin
            gr_sel[GA] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LPc] = 1'b1; state_d = StT0;
          end
          default: state_d = StT0;
        endcase
      end
      StT5: begin
        run = 1'b1;
        state_d = StT6;
        case (op)
          OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr, OpAddi, OpAndi, OpOri,
          OpLdi: begin
            bus_src[BZLow] = 1'b1; gr_sel[GA] = 1'b1; reg_ld[LR] = 1'b1; state_d = StT0;
          end
          OpMul, OpDiv: begin
            bus_src[BZLow] = 1'b1; reg_ld[LLo] = 1'b1;
          end
          OpLd, OpSt: begin
            bus_src[BZLow] = 1'b1; reg_ld[LMar] = 1'b1;
          end
          OpBr: begin
            bus_src[BC] = 1'b1; reg_ld[LZLow] = 1'b1; alu_add = 1'b1;
          end
          default: state_d = StT0;
        endcase
      end
      StT6: begin
        run = 1'b1;
        state_d = StT0;
        case (op)
          OpMul, OpDiv: begin
            bus_src[BZHigh] = 1'b1; reg_ld[LHi] = 1'b1;
          end
          OpLd: begin
            mem_read = 1'b1; reg_ld[LMdr] = 1'b1; state_d = StT7;
          end
          OpSt: begin
            gr_sel[GA] = 1'b1; bus_src[BR] = 1'b1; reg_ld[LMdr] = 1'b1; state_d = StT7;
          end
          // Branch target is taken only when the CON FF is set this cycle.
          OpBr: begin
            bus_src[BZLow] = 1'b1; reg_ld[LPc] = cs.con_ff;
          end
          default: state_d = StT0;
        endcase
      end
      StT7: begin
        run = 1'b1;
        state_d = StT0;
        case (op)
          OpLd: begin
            bus_src[BMdr] = 1'b1; gr_sel[GA] = 1'b1; reg_ld[LR] = 1'b1;
          end
          OpSt:    mem_write = 1'b1;
          default: state_d = StT0;
        endcase
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  assign cs.bus_src   = bus_src;
  assign cs.reg_ld    = reg_ld;
  assign cs.gr_sel    = gr_sel;
  assign cs.inc_pc    = inc_pc;
  assign cs.mem_read  = mem_read;
  assign cs.mem_write = mem_write;
  assign cs.alu_add   = alu_add;
  assign cs.link_r15  = link_r15;
  assign cs.run       = run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instructions through fetch and
// execute, comparing every control output against hand-derived vectors.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_on  = 1'b0;

  // Flag order: {inc_pc, mem_read, mem_write, alu_add, link_r15, run}
  localparam logic [5:0] FR   = 6'b000001;
  localparam logic [5:0] FINC = 6'b100000;
  localparam logic [5:0] FMRD = 6'b010000;
  localparam logic [5:0] FMWR = 6'b001000;
  localparam logic [5:0] FADD = 6'b000100;
  localparam logic [5:0] FLNK = 6'b000010;

  localparam logic [31:0] IrJr   = 32'h98800000;
  localparam logic [31:0] IrLd   = 32'h00800055;
  localparam logic [31:0] IrSt   = 32'h10800000;
  localparam logic [31:0] IrBr   = 32'h90800000;
  localparam logic [31:0] IrMul  = 32'h70000000;
  localparam logic [31:0] IrJal  = 32'hA0000000;
  localparam logic [31:0] IrNop  = 32'hC8000000;
  localparam logic [31:0] IrUndf = 32'hF8000000;
  localparam logic [31:0] IrAdd  = 32'h18000000;
  localparam logic [31:0] IrHalt = 32'hD0000000;

  control_sequencer_if #(.WORD(32)) cs ();

  control_sequencer #(.OPW(5), .WORD(32)) dut (
    .clk (clk),
    .clr (clr),
    .cs  (cs)
  );

  always #5 clk = ~clk;

  // Never more than one bus driver.
  always @(negedge clk) begin
    if (mon_on) begin
      n_tests++;
      assert ($onehot0(cs.bus_src)) else begin
        n_fail++;
        $error("FAIL onehot0 observed=%b required=onehot0", cs.bus_src);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] b, input logic [11:0] r,
                     input logic [2:0] g, input logic [5:0] f);
    logic [30:0] obs;
    logic [30:0] exp;
    obs = {cs.bus_src, cs.reg_ld, cs.gr_sel, cs.inc_pc, cs.mem_read, cs.mem_write,
           cs.alu_add, cs.link_r15, cs.run};
    exp = {b, r, g, f};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Steps through T0..T2; the new IR value is applied once T0 is reached.
  task automatic fetch(input logic [31:0] new_ir);
    step();
    cs.ir = new_ir;
    chk("t0", 10'h001, 12'h021, 3'b000, FINC | FR);
    step();
    chk("t1", 10'h008, 12'h006, 3'b000, FMRD | FR);
    step();
    chk("t2", 10'h002, 12'h008, 3'b000, FR);
  endtask

  initial begin
    cs.ir     = '0;
    cs.con_ff = 1'b0;
    clr       = 1'b1;
    step();
    chk("rst", 10'h000, 12'h000, 3'b000, 6'b0);
    mon_on = 1'b1;
    clr    = 1'b0;

    // jr R1
    fetch(IrJr);
    step(); chk("jr_t3", 10'h100, 12'h002, 3'b100, FR);

    // ld
    fetch(IrLd);
    step(); chk("ld_t3", 10'h200, 12'h010, 3'b010, FR);
    step(); chk("ld_t4", 10'h080, 12'h020, 3'b000, FADD | FR);
    step(); chk("ld_t5", 10'h008, 12'h001, 3'b000, FR);
    step(); chk("ld_t6", 10'h000, 12'h004, 3'b000, FMRD | FR);
    step(); chk("ld_t7", 10'h002, 12'h200, 3'b100, FR);

    // st
    fetch(IrSt);
    step(); chk("st_t3", 10'h200, 12'h010, 3'b010, FR);
    step(); chk("st_t4", 10'h080, 12'h020, 3'b000, FADD | FR);
    step(); chk("st_t5", 10'h008, 12'h001, 3'b000, FR);
    step(); chk("st_t6", 10'h100, 12'h004, 3'b100, FR);
    step(); chk("st_t7", 10'h000, 12'h000, 3'b000, FMWR | FR);

    // br, not taken then taken
    for (int k = 0; k < 2; k++) begin
      cs.con_ff = 1'b0;
      fetch(IrBr);
      step(); chk("br_t3", 10'h100, 12'h800, 3'b100, FR);
      step(); chk("br_t4", 10'h001, 12'h010, 3'b000, FR);
      step(); chk("br_t5", 10'h080, 12'h020, 3'b000, FADD | FR);
      cs.con_ff = (k == 1);
      step();
      if (k == 0) chk("br_t6_nt", 10'h008, 12'h000, 3'b000, FR);
      else        chk("br_t6_tk", 10'h008, 12'h002, 3'b000, FR);
    end
    cs.con_ff = 1'b0;

    // mul
    fetch(IrMul);
    step(); chk("mul_t3", 10'h100, 12'h010, 3'b100, FR);
    step(); chk("mul_t4", 10'h100, 12'h060, 3'b010, FR);
    step(); chk("mul_t5", 10'h008, 12'h080, 3'b000, FR);
    step(); chk("mul_t6", 10'h004, 12'h100, 3'b000, FR);

    // jal
    fetch(IrJal);
    step(); chk("jal_t3", 10'h001, 12'h200, 3'b000, FLNK | FR);
    step(); chk("jal_t4", 10'h100, 12'h002, 3'b100, FR);

    // nop and an undefined opcode: T2 straight back to T0 (checked by next fetch)
    fetch(IrNop);
    fetch(IrUndf);

    // add interrupted by clr in T5
    fetch(IrAdd);
    step(); chk("add_t3", 10'h100, 12'h010, 3'b010, FR);
    step(); chk("add_t4", 10'h100, 12'h020, 3'b001, FR);
    step(); chk("add_t5", 10'h008, 12'h200, 3'b100, FR);
    clr = 1'b1;
    step(); chk("add_clr_rst", 10'h000, 12'h000, 3'b000, 6'b0);
    clr = 1'b0;

    // halt: T3 idle, then HALT for 20 cycles until clr
    fetch(IrHalt);
    step(); chk("halt_t3", 10'h000, 12'h000, 3'b000, FR);
    for (int i = 0; i < 20; i++) begin
      step(); chk("halt_hold", 10'h000, 12'h000, 3'b000, 6'b0);
    end
    clr = 1'b1;
    step(); chk("halt_clr_rst", 10'h000, 12'h000, 3'b000, 6'b0);
    clr = 1'b0;
    fetch(IrJr);
    step(); chk("jr2_t3", 10'h100, 12'h002, 3'b100, FR);
    step(); chk("jr2_t0", 10'h001, 12'h021, 3'b000, FINC | FR);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
